// File: rtl/jk_bank_driver.sv
// jk_bank_driver: command-side controller for a bank of WIDTH JK flip-flops.
// Accepts LOAD (set bank to a target) or COUNT (increment bank N times) commands
// over valid/ready, drives per-bit j/k with toggle excitation (j == k always),
// then watches q_fb and pulses done on a match or err after TIMEOUT misses.

module jk_bank_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Miss counter only needs to reach TIMEOUT-1 before err fires.
  localparam int unsigned MissW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadDrv,
    StSettle,
    StStepDrv,
    StStepGap,
    StCheck
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   drive_q, drive_d;   // shared j/k drive, toggle-only excitation
  logic [WIDTH-1:0]   exp_q, exp_d;       // value the bank must show in CHECK
  logic [WIDTH-1:0]   rem_q, rem_d;       // remaining count steps
  logic [MissW-1:0]   miss_q, miss_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   carry;

  // Increment toggle mask from live q_fb: bit i toggles when all lower bits are 1.
  always_comb begin
    logic run;
    run   = 1'b1;
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = run;
      run      = run & q_fb[i];
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      drive_q <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      miss_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      miss_q  <= miss_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-datapath logic; drive defaults to 00 (bank holds).
  always_comb begin
    state_d = state_q;
    drive_d = '0;
    exp_d   = exp_q;
    rem_d   = rem_q;
    miss_d  = miss_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          miss_d = '0;
          if (!cmd_mode) begin
            exp_d   = cmd_data;
            state_d = StLoadDrv;
          end else begin
            rem_d   = cmd_data;
            exp_d   = q_fb + cmd_data;
            state_d = (cmd_data == '0) ? StCheck : StStepDrv;
          end
        end
      end
      StLoadDrv: begin
        // Toggle only the bits that differ from the target.
        drive_d = q_fb ^ exp_q;
        state_d = StSettle;
      end
      StSettle: begin
        state_d = StCheck;
      end
      StStepDrv: begin
        drive_d = carry;
        rem_d   = rem_q - WIDTH'(1);
        state_d = StStepGap;
      end
      StStepGap: begin
        state_d = (rem_q == '0) ? StCheck : StStepDrv;
      end
      StCheck: begin
        if (q_fb == exp_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (miss_q == MissW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          miss_d = miss_q + MissW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: handshake/status decoded from state, drives and pulses registered.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    j         = drive_q;
    k         = drive_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a 4-bit JK bank on j/k/q_fb, directed scenarios plus
// randomized commands, each checked cycle by cycle against a command-level model
// (target value, count arithmetic, increment toggle mask q^(q+1), fixed latencies).

module tb_jk_bank_driver;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  logic [WIDTH-1:0] bank_q;
  logic             bank_set;
  logic [WIDTH-1:0] bank_val;
  logic             disc;
  logic [WIDTH-1:0] mq;

  int n_checks = 0;
  int n_errors = 0;

  jk_bank_driver #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_data  (cmd_data),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank with a bench-side preset; disc models a broken feedback path.
  always @(posedge clk) begin
    if (bank_set) begin
      bank_q <= bank_val;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: ;
        endcase
      end
    end
  end

  assign q_fb = disc ? '0 : bank_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bank_set = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_set = 1'b0;
    mq       = v;
  endtask

  // Issue one command and check every cycle until one cycle past completion.
  // abort_in >= 0 asserts reset for two cycles after that sample instead.
  task automatic run_cmd(input bit mode, input logic [WIDTH-1:0] data, input bit spam,
                         input int abort_in);
    logic [WIDTH-1:0] q0, qfb0, ej, eq, cur;
    int lat, abort_n, steps, nn;
    bit fail;
    q0   = mq;
    qfb0 = disc ? '0 : mq;
    nn   = int'(data);
    if (!mode) begin
      fail = disc && (data != '0);
      lat  = fail ? 2 + int'(TIMEOUT) : 3;
    end else begin
      fail = 1'b0;
      lat  = 2 * nn + 1;
    end
    abort_n = (abort_in >= lat) ? lat - 1 : abort_in;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_data  = data;
    for (int n = 0; n <= lat + 1; n++) begin
      @(posedge clk);
      #1;
      if (!mode) begin
        ej = (n == 1) ? (qfb0 ^ data) : '0;
        eq = (n >= 2) ? data : q0;
      end else begin
        steps = (n / 2 < nn) ? n / 2 : nn;
        eq    = q0 + WIDTH'(steps);
        cur   = q0 + WIDTH'((n - 1) / 2);
        ej    = ((n % 2 == 1) && (n < 2 * nn)) ? (cur ^ (cur + 4'd1)) : '0;
      end
      check_eq("j", 32'(j), 32'(ej));
      check_eq("k", 32'(k), 32'(ej));
      if (!disc) check_eq("q_fb", 32'(q_fb), 32'(eq));
      check_eq("done", 32'(done), 32'(n == lat && !fail));
      check_eq("err", 32'(err), 32'(n == lat && fail));
      check_eq("busy", 32'(busy), 32'(n < lat));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(n >= lat));
      @(negedge clk);
      if (n == abort_n) begin
        // Bank still applies the drive present in this cycle at the reset edge.
        mq        = eq ^ ej;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
          check_eq("rst_j", 32'(j), 32'(0));
          check_eq("rst_k", 32'(k), 32'(0));
          check_eq("rst_busy", 32'(busy), 32'(0));
          check_eq("rst_done", 32'(done), 32'(0));
          check_eq("rst_err", 32'(err), 32'(0));
          check_eq("rst_q_fb", 32'(q_fb), 32'(mq));
          @(negedge clk);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 32'(1));
        check_eq("post_rst_busy", 32'(busy), 32'(0));
        check_eq("post_rst_done", 32'(done), 32'(0));
        check_eq("post_rst_err", 32'(err), 32'(0));
        check_eq("post_rst_j", 32'(j), 32'(0));
        return;
      end
      cmd_valid = spam && (n < lat);
      if (spam) begin
        cmd_mode = 1'($urandom);
        cmd_data = WIDTH'($urandom);
      end
    end
    cmd_valid = 1'b0;
    if (!disc) mq = mode ? (q0 + data) : data;
  endtask

  initial begin
    bit               m, s;
    logic [WIDTH-1:0] d;
    int               ab;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_data  = '0;
    bank_set  = 1'b1;
    bank_val  = '0;
    disc      = 1'b0;
    mq        = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_j", 32'(j), 32'(0));
    check_eq("reset_k", 32'(k), 32'(0));
    check_eq("reset_busy", 32'(busy), 32'(0));
    check_eq("reset_done", 32'(done), 32'(0));
    check_eq("reset_err", 32'(err), 32'(0));
    @(negedge clk);
    reset    = 1'b0;
    bank_set = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_ready", 32'(cmd_ready), 32'(1));

    // LOAD from 0000 to 1010.
    preset(4'b0000);
    run_cmd(1'b0, 4'b1010, 1'b0, -1);
    // LOAD equal to current value, with commands thrown at it while busy.
    preset(4'b0110);
    run_cmd(1'b0, 4'b0110, 1'b1, -1);
    // COUNT 5 across the wrap.
    preset(4'b1110);
    run_cmd(1'b1, 4'd5, 1'b0, -1);
    // Disconnected bank: timeout path.
    preset(4'b0000);
    disc = 1'b1;
    run_cmd(1'b0, 4'b0110, 1'b0, -1);
    @(negedge clk);
    disc = 1'b0;
    preset(4'b0011);
    // COUNT 8 abandoned by reset after two steps, then a clean LOAD.
    run_cmd(1'b1, 4'd8, 1'b0, 4);
    run_cmd(1'b0, 4'b0001, 1'b0, -1);
    // COUNT 0 completes straight from CHECK.
    run_cmd(1'b1, 4'd0, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) preset(WIDTH'($urandom));
      m  = 1'($urandom);
      d  = WIDTH'($urandom);
      s  = 1'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : -1;
      run_cmd(m, d, s, ab);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
